// File: rtl/ldpe_gate_seq_if.sv
// Request/data and latch-bank drive signals for ldpe_gate_seq.
// The master is the requester; the slave is the sequencer.
interface ldpe_gate_seq_if #(
  parameter int unsigned WIDTH = 8
);
  logic             REQ;
  logic [WIDTH-1:0] DIN;
  logic             PRE_REQ;
  logic [WIDTH-1:0] D;
  logic             G;
  logic             GE;
  logic             PRE;
  logic             ACK;
  logic             BUSY;

  modport master (
    output REQ, DIN, PRE_REQ,
    input  D, G, GE, PRE, ACK, BUSY
  );

  modport slave (
    input  REQ, DIN, PRE_REQ,
    output D, G, GE, PRE, ACK, BUSY
  );
endinterface

// File: rtl/ldpe_gate_seq.sv
// Sequencer generating D/GE/G/PRE waveforms for a bank of LDPE latches.
// Optional preset path is enabled by defining LDPE_GATE_SEQ_PRESET_EN.
module ldpe_gate_seq #(
  parameter int unsigned WIDTH     = 8,
  parameter logic        INIT      = 1'b1,
  parameter int unsigned SETUP_CYC = 1,
  parameter int unsigned OPEN_CYC  = 2,
  parameter int unsigned HOLD_CYC  = 1,
  parameter int unsigned PRE_CYC   = 2
) (
  input logic            C,
  input logic            RN,
  ldpe_gate_seq_if.slave bus
);

  localparam int unsigned S_EFF   = (SETUP_CYC == 32'd0) ? 32'd1 : SETUP_CYC;
  localparam int unsigned O_EFF   = (OPEN_CYC  == 32'd0) ? 32'd1 : OPEN_CYC;
  localparam int unsigned H_EFF   = (HOLD_CYC  == 32'd0) ? 32'd1 : HOLD_CYC;
  localparam int unsigned SO_MAX  = (S_EFF > O_EFF) ? S_EFF : O_EFF;
  localparam int unsigned SOH_MAX = (SO_MAX > H_EFF) ? SO_MAX : H_EFF;
`ifdef LDPE_GATE_SEQ_PRESET_EN
  localparam int unsigned P_EFF   = (PRE_CYC == 32'd0) ? 32'd1 : PRE_CYC;
  localparam int unsigned MAX_CYC = (P_EFF > SOH_MAX) ? P_EFF : SOH_MAX;
`else
  localparam int unsigned MAX_CYC = SOH_MAX;
`endif
  // Counter holds "remaining cycles minus one", so MAX_CYC-1 must fit.
  localparam int unsigned CNT_W = (MAX_CYC > 32'd1) ? $clog2(MAX_CYC) : 32'd1;
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(32'd0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
  localparam logic [CNT_W-1:0] S_LOAD   = CNT_W'(S_EFF - 32'd1);
  localparam logic [CNT_W-1:0] O_LOAD   = CNT_W'(O_EFF - 32'd1);
  localparam logic [CNT_W-1:0] H_LOAD   = CNT_W'(H_EFF - 32'd1);
`ifdef LDPE_GATE_SEQ_PRESET_EN
  localparam logic [CNT_W-1:0] P_LOAD   = CNT_W'(P_EFF - 32'd1);
`endif

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    OPEN  = 3'd2,
    HOLD  = 3'd3,
    DONE  = 3'd4
`ifdef LDPE_GATE_SEQ_PRESET_EN
    , PRESET = 3'd5
`endif
  } state_t;

  state_t             state_r, state_n;
  logic [CNT_W-1:0]   cnt_r, cnt_n;
  logic [WIDTH-1:0]   d_r, d_n;
  logic               g_r, g_n;
  logic               ge_r, ge_n;
  logic               ack_r, ack_n;
  logic               busy_r, busy_n;
  logic               armed_r, armed_n;
`ifdef LDPE_GATE_SEQ_PRESET_EN
  logic               pre_r, pre_n;
`else
  logic               pre_req_unused_s;
  assign pre_req_unused_s = bus.PRE_REQ;
`endif

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge C) begin
    if (!RN) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      d_r     <= {WIDTH{INIT}};
      g_r     <= 1'b0;
      ge_r    <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
      armed_r <= 1'b1;
`ifdef LDPE_GATE_SEQ_PRESET_EN
      pre_r   <= 1'b0;
`endif
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      d_r     <= d_n;
      g_r     <= g_n;
      ge_r    <= ge_n;
      ack_r   <= ack_n;
      busy_r  <= busy_n;
      armed_r <= armed_n;
`ifdef LDPE_GATE_SEQ_PRESET_EN
      pre_r   <= pre_n;
`endif
    end
  end

  // Next-state and next-output logic; every window counts down to zero.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    d_n     = d_r;
    g_n     = g_r;
    ge_n    = ge_r;
    ack_n   = 1'b0;
`ifdef LDPE_GATE_SEQ_PRESET_EN
    pre_n   = pre_r;
`endif
    case (state_r)
      IDLE: begin
`ifdef LDPE_GATE_SEQ_PRESET_EN
        if (bus.PRE_REQ) begin
          state_n = PRESET;
          pre_n   = 1'b1;
          cnt_n   = P_LOAD;
        end else
`endif
        if (bus.REQ && armed_r) begin
          state_n = SETUP;
          d_n     = bus.DIN;
          ge_n    = 1'b1;
          cnt_n   = S_LOAD;
        end else begin
          state_n = IDLE;
        end
      end
      SETUP: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = OPEN;
          g_n     = 1'b1;
          cnt_n   = O_LOAD;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      OPEN: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = HOLD;
          g_n     = 1'b0;
          cnt_n   = H_LOAD;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      HOLD: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = DONE;
          ge_n    = 1'b0;
          ack_n   = 1'b1;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
`ifdef LDPE_GATE_SEQ_PRESET_EN
      PRESET: begin
        if (cnt_r == CNT_ZERO) begin
          state_n = IDLE;
          pre_n   = 1'b0;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
`endif
      default: begin
        state_n = IDLE;
        cnt_n   = CNT_ZERO;
        g_n     = 1'b0;
        ge_n    = 1'b0;
`ifdef LDPE_GATE_SEQ_PRESET_EN
        pre_n   = 1'b0;
`endif
      end
    endcase

    // A request held high across ACK must be released before it re-arms.
    if (ack_n) begin
      armed_n = 1'b0;
    end else if (!bus.REQ) begin
      armed_n = 1'b1;
    end else begin
      armed_n = armed_r;
    end

    busy_n = (state_n != IDLE);
  end

  assign bus.D    = d_r;
  assign bus.G    = g_r;
  assign bus.GE   = ge_r;
  assign bus.ACK  = ack_r;
  assign bus.BUSY = busy_r;
`ifdef LDPE_GATE_SEQ_PRESET_EN
  assign bus.PRE  = pre_r;
`else
  assign bus.PRE  = 1'b0;
`endif

endmodule
